// File: rtl/cr_kme_bimc_pkg.sv
// Shared definitions for the BIMC chain master: frame field widths, FSM states
// and chain command opcodes.
package cr_kme_bimc_pkg;

  localparam int CMD_W       = 4;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 24;
  localparam int FRAME_W_DEF = CMD_W + ADDR_W + DATA_W;
  localparam int TO_W        = 11;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'h0;
  localparam logic [CMD_W-1:0] CMD_RD  = 4'h1;
  localparam logic [CMD_W-1:0] CMD_WR  = 4'h2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RSP   = 2'd3
  } state_t;

endpackage

// File: rtl/cr_kme_bimc_rx_deser.sv
// Capture shifter for the frame returning from the chain tail. A sync pulse while
// armed and idle starts a capture; o_done/o_frame are valid in the last bit's cycle.
module cr_kme_bimc_rx_deser #(
  parameter int FRAME_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_arm,
  input  logic               i_isync,
  input  logic               i_idat,
  output logic               o_busy,
  output logic               o_done,
  output logic [FRAME_W-1:0] o_frame
);

  localparam int CNT_W = $clog2(FRAME_W);

  logic               r_active;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-2:0] r_sr;

  logic               w_start;
  logic               w_shift;
  logic [CNT_W-1:0]   w_cnt_cur;

  // Sync is only honoured between captures, so a stray pulse mid-frame is dropped.
  assign w_start   = i_arm && i_isync && !r_active;
  assign w_shift   = w_start || r_active;
  assign w_cnt_cur = w_start ? '0 : r_cnt;

  assign o_busy  = w_shift;
  assign o_done  = w_shift && (w_cnt_cur == CNT_W'(FRAME_W - 1));
  assign o_frame = {r_sr, i_idat};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_sr     <= '0;
    end else if (w_shift) begin
      r_sr <= o_frame[FRAME_W-2:0];
      if (o_done) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_active <= 1'b1;
        r_cnt    <= w_cnt_cur + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cr_kme_bimc_chain_master.sv
// BIMC chain master: serialises one host request into the chain head, captures
// the frame returning from the tail (or times out) and holds it for the host.
module cr_kme_bimc_chain_master
  import cr_kme_bimc_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ack,
  output logic [CMD_W-1:0]  rsp_cmd,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              bimc_odat,
  output logic              bimc_osync,
  input  logic              bimc_idat,
  input  logic              bimc_isync
);

  localparam int TXC_W = $clog2(FRAME_W);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-2:0] r_tx;
  logic [TXC_W-1:0]   r_tx_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_odat;
  logic               r_osync;
  logic [CMD_W-1:0]   r_rsp_cmd;
  logic [ADDR_W-1:0]  r_rsp_addr;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_to;

  logic [FRAME_W-1:0] w_req_frame;
  logic [FRAME_W-1:0] w_rx_frame;
  logic               w_arm;
  logic               w_rx_busy;
  logic               w_rx_done;
  logic               w_accept;
  logic               w_cap_done;
  logic               w_timeout;
  logic               w_tx_step;

  assign w_req_frame = FRAME_W'({req_cmd, req_addr, req_wdata});
  assign w_arm       = (r_state == ST_SHIFT) || (r_state == ST_WAIT);
  assign w_tx_step   = (r_state == ST_SHIFT) && (w_state_nxt == ST_SHIFT);

  cr_kme_bimc_rx_deser #(
    .FRAME_W (FRAME_W)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .i_arm   (w_arm),
    .i_isync (bimc_isync),
    .i_idat  (bimc_idat),
    .o_busy  (w_rx_busy),
    .o_done  (w_rx_done),
    .o_frame (w_rx_frame)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A capture finishing while still transmitting wins: the tx frame is truncated.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cap_done  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_rx_done) begin
          w_cap_done  = 1'b1;
          w_state_nxt = ST_RSP;
        end else if (r_tx_cnt == TXC_W'(FRAME_W - 1)) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_rx_done) begin
          w_cap_done  = 1'b1;
          w_state_nxt = ST_RSP;
        end else if (!w_rx_busy && (r_to_cnt == TO_W'(TIMEOUT - 1))) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_odat always mirrors the bit currently on the wire; r_tx holds the rest.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx        <= '0;
      r_tx_cnt    <= '0;
      r_to_cnt    <= '0;
      r_odat      <= 1'b0;
      r_osync     <= 1'b0;
      r_rsp_cmd   <= '0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_odat  <= 1'b0;
      r_osync <= 1'b0;
      if (w_accept) begin
        r_tx     <= w_req_frame[FRAME_W-2:0];
        r_odat   <= w_req_frame[FRAME_W-1];
        r_osync  <= 1'b1;
        r_tx_cnt <= '0;
        r_to_cnt <= '0;
      end else if (w_tx_step) begin
        r_odat   <= r_tx[FRAME_W-2];
        r_tx     <= {r_tx[FRAME_W-3:0], 1'b0};
        r_tx_cnt <= r_tx_cnt + TXC_W'(1);
      end
      if ((r_state == ST_WAIT) && !w_rx_busy) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_cap_done) begin
        r_rsp_cmd   <= w_rx_frame[FRAME_W-1 -: CMD_W];
        r_rsp_addr  <= w_rx_frame[ADDR_W+DATA_W-1 -: ADDR_W];
        r_rsp_rdata <= w_rx_frame[DATA_W-1:0];
        r_rsp_to    <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_cmd   <= '0;
        r_rsp_addr  <= '0;
        r_rsp_rdata <= '0;
        r_rsp_to    <= 1'b1;
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RSP);
  assign rsp_cmd     = r_rsp_cmd;
  assign rsp_addr    = r_rsp_addr;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_to;
  assign bimc_odat   = r_odat;
  assign bimc_osync  = r_osync;

endmodule

// File: tb/tb_cr_kme_bimc_chain_master.sv
// Directed bench for cr_kme_bimc_chain_master: loopback, delayed chain, timeout,
// spurious sync, mid-frame reset and a long-held response, with a response scoreboard.
module tb_cr_kme_bimc_chain_master;
  import cr_kme_bimc_pkg::*;

  localparam int FW    = 40;
  localparam int TO    = 1024;
  localparam int LIMIT = FW + TO + 100;

  typedef struct packed {
    logic [3:0]  c;
    logic [11:0] a;
    logic [23:0] d;
    logic        t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [11:0] req_addr;
  logic [23:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ack;
  logic [3:0]  rsp_cmd;
  logic [11:0] rsp_addr;
  logic [23:0] rsp_rdata;
  logic        rsp_timeout;
  logic        bimc_odat;
  logic        bimc_osync;
  logic        bimc_idat;
  logic        bimc_isync;

  int          checks = 0;
  int          errors = 0;
  int          mode   = 0;   // 0 loopback, 1 seven-cycle chain, 2 no return
  logic        spur   = 1'b0;
  logic [6:0]  dly    = '0;
  logic [6:0]  sdly   = '0;
  exp_t        q[$];

  assign bimc_idat  = (mode == 0) ? bimc_odat  : (mode == 1) ? dly[6]  : 1'b0;
  assign bimc_isync = ((mode == 0) ? bimc_osync : (mode == 1) ? sdly[6] : 1'b0) | spur;

  cr_kme_bimc_chain_master #(
    .FRAME_W (FW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ack     (rsp_ack),
    .rsp_cmd     (rsp_cmd),
    .rsp_addr    (rsp_addr),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .bimc_odat   (bimc_odat),
    .bimc_osync  (bimc_osync),
    .bimc_idat   (bimc_idat),
    .bimc_isync  (bimc_isync)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dly  <= {dly[5:0], bimc_odat};
    sdly <= {sdly[5:0], bimc_osync};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called during an IDLE cycle; returns in the first cycle after the accept edge.
  task automatic start_req(input logic [3:0] c, input logic [11:0] a, input logic [23:0] d);
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_lat, input int spur_k, output exp_t e);
    int k;
    int ready_seen;
    k = 1;
    ready_seen = 0;
    forever begin
      spur = (k == spur_k);
      if (rsp_valid || k >= LIMIT) break;
      if (req_ready) ready_seen++;
      @(posedge clk); #1;
      k++;
    end
    spur = 1'b0;
    check({tag, "_latency"}, k, exp_lat);
    check({tag, "_ready_busy"}, ready_seen, 0);
    if (q.size() == 0) begin
      e = '0;
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      check({tag, "_fields"}, {rsp_cmd, rsp_addr, rsp_rdata, rsp_timeout}, e);
    end
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ack = 1'b1;
    @(posedge clk); #1;
    rsp_ack = 1'b0;
    check({tag, "_ack_valid"}, rsp_valid, 0);
    check({tag, "_ack_ready"}, req_ready, 1);
  endtask

  initial begin
    exp_t e;
    int   seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ack   = 1'b0;
    req_cmd   = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_serial", {bimc_odat, bimc_osync}, 0);
    check("rst_fields", {rsp_cmd, rsp_addr, rsp_rdata, rsp_timeout}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    mode = 0;
    q.push_back('{c: CMD_RD, a: 12'h0A5, d: 24'h123456, t: 1'b0});
    start_req(CMD_RD, 12'h0A5, 24'h123456);
    check("lb_osync_t1", bimc_osync, 1);
    check("lb_odat_t1", bimc_odat, 0);
    wait_rsp("lb", FW + 1, 0, e);
    ack_rsp("lb");

    mode = 1;
    q.push_back('{c: CMD_WR, a: 12'hFFF, d: 24'hFFFFFF, t: 1'b0});
    start_req(CMD_WR, 12'hFFF, 24'hFFFFFF);
    wait_rsp("d7", FW + 8, 0, e);
    ack_rsp("d7");

    mode = 2;
    q.push_back('{c: 4'h0, a: 12'h000, d: 24'h000000, t: 1'b1});
    start_req(CMD_RD, 12'h123, 24'h456789);
    wait_rsp("tmo", FW + TO + 1, 0, e);
    ack_rsp("tmo");

    mode = 0;
    q.push_back('{c: CMD_RD, a: 12'h3C3, d: 24'hA5A5A5, t: 1'b0});
    start_req(CMD_RD, 12'h3C3, 24'hA5A5A5);
    wait_rsp("spur", FW + 1, 6, e);
    ack_rsp("spur");

    start_req(CMD_WR, 12'h456, 24'h789ABC);
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_serial", {bimc_odat, bimc_osync}, 0);
    check("abort_ready", req_ready, 1);
    seen = 0;
    repeat (100) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_rsp", seen, 0);

    q.push_back('{c: CMD_WR, a: 12'h5A5, d: 24'h0F0F0F, t: 1'b0});
    start_req(CMD_WR, 12'h5A5, 24'h0F0F0F);
    wait_rsp("hold", FW + 1, 0, e);
    req_valid = 1'b1;
    req_cmd   = CMD_RD;
    req_addr  = 12'h777;
    req_wdata = 24'h00BEEF;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (!rsp_valid || req_ready || ({rsp_cmd, rsp_addr, rsp_rdata, rsp_timeout} !== e)) seen++;
    end
    check("hold_stable", seen, 0);
    rsp_ack = 1'b1;
    @(posedge clk); #1;
    rsp_ack = 1'b0;
    check("hold_idle_valid", rsp_valid, 0);
    check("hold_idle_ready", req_ready, 1);
    q.push_back('{c: CMD_RD, a: 12'h777, d: 24'h00BEEF, t: 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("hold_new_accept", req_ready, 0);
    wait_rsp("after", FW + 1, 0, e);
    ack_rsp("after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_kme_bimc_chain_master.md
CR_KME_BIMC_CHAIN_MASTER -- requirements
Module: cr_kme_bimc_chain_master

Interface
REQ-001 Parameter FRAME_W, default 40, serial frame length in bits: cmd[39:36], addr[35:24], data[23:0].
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles to wait for the returning frame after the last transmitted bit.
REQ-003 clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  master idle and can accept a request.
REQ-007 req_cmd  in  4  chain command opcode.
REQ-008 req_addr  in  12  memory/word address.
REQ-009 req_wdata  in  24  write data.
REQ-010 rsp_valid  out  1  response held for the host.
REQ-011 rsp_ack  in  1  host consumes the response.
REQ-012 rsp_cmd  out  4  returned cmd field.
REQ-013 rsp_addr  out  12  returned addr field.
REQ-014 rsp_rdata  out  24  returned data field.
REQ-015 rsp_timeout  out  1  response is a timeout; payload fields are zero.
REQ-016 bimc_odat  out  1  serial data into the chain head.
REQ-017 bimc_osync  out  1  frame-start marker into the chain head.
REQ-018 bimc_idat  in  1  serial data returning from the chain tail.
REQ-019 bimc_isync  in  1  frame-start marker returning from the chain tail.

Function
REQ-020 FSM states: IDLE, SHIFT, WAIT, RSP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on req_valid, load {req_cmd,req_addr,req_wdata} into the tx shift register, clear tx_cnt, go to SHIFT.
REQ-022 SHIFT: bimc_odat = tx MSB, shift left one bit per cycle, bimc_osync = 1 only when tx_cnt==0; after FRAME_W bits go to WAIT.
REQ-023 Accept at edge T -> osync/MSB at cycle T+1, LSB at cycle T+FRAME_W; bimc_odat and bimc_osync SHALL be registered and 0 outside SHIFT.
REQ-024 Receiver armed in SHIFT and WAIT: bimc_isync=1 with rx inactive starts capture; bimc_idat in that cycle is the frame MSB.
REQ-025 Capture shifts bimc_idat MSB-first for FRAME_W cycles; bimc_isync during an active capture SHALL be ignored.
REQ-026 Capture complete: load rsp_cmd/rsp_addr/rsp_rdata, rsp_timeout=0, go to RSP; capture completing in SHIFT SHALL also go to RSP, with the tx frame truncated and outputs returned to 0.
REQ-027 WAIT: 11-bit timeout counter increments while no capture is active; on reaching TIMEOUT-1, go to RSP with rsp_timeout=1 and payload zero.
REQ-028 An active capture SHALL suspend the timeout, so a frame started before expiry always completes.
REQ-029 RSP: rsp_valid=1 with fields stable until rsp_ack; on rsp_ack go to IDLE the next cycle; bimc_isync in IDLE/RSP SHALL be ignored.
REQ-030 req_valid outside IDLE SHALL have no effect; back-to-back requests SHALL be separated by at least one IDLE cycle.

Reset
REQ-031 rst SHALL force IDLE, clear counters and shift registers, and drive req_ready=1 and all other outputs 0 on the cycle after assertion.
REQ-032 rst mid-frame SHALL abort transmit and capture with no response emitted.

Structure
REQ-033 Shared package cr_kme_bimc_pkg: FSM state enum, field widths (4/12/24), FRAME_W default, and command opcode constants (RD=4'h1, WR=4'h2, NOP=4'h0).
REQ-034 One sub-module, cr_kme_bimc_rx_deser (capture shifter and bit counter); the FSM and tx shifter SHALL live in the top.

Verification
REQ-035 Loopback (odat->idat, osync->isync, 0 delay), req {1,0x0A5,0x123456} -> rsp_valid at T+FRAME_W+1 with cmd 1, addr 0x0A5, rdata 0x123456, timeout 0.
REQ-036 Chain delay 7 cycles, req {2,0xFFF,0xFFFFFF} -> identical fields returned, rsp at T+FRAME_W+8.
REQ-037 No return (isync tied 0) -> rsp_timeout=1 after exactly TIMEOUT WAIT cycles, payload 0, req_ready=0 throughout.
REQ-038 Spurious isync pulse 5 cycles into a capture -> ignored; frame captured intact.
REQ-039 rst asserted at bit 20 of SHIFT -> next cycle odat=osync=0, req_ready=1; no rsp_valid ever.
REQ-040 rsp_ack held 0 for 50 cycles -> rsp_valid and fields stable; req_valid ignored until ack plus one cycle.
